// File: rtl/ctrl_pkg.sv
// Shared constants and state encoding for the decode/sequencing stage.
package ctrl_pkg;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_AW    = $clog2(LUT_DEPTH);
  localparam int TGT_W     = 8;
  localparam int CNT_W     = 16;

  localparam logic [2:0] OP_BR      = 3'b110;
  localparam logic [2:0] OP_BRZ     = 3'b111;
  localparam logic [8:0] INSTR_HALT = 9'b101_111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_HALTED
  } state_t;
endpackage

// File: rtl/ctrl_decode_if.sv
// Bundle between fetch/execute and the decode stage; slave is the decoder side.
interface ctrl_decode_if;
  import ctrl_pkg::*;

  logic              go;
  logic [8:0]        instruction;
  logic              zero_in;
  logic              zero_we;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [TGT_W-1:0]  lut_data;

  logic              start;
  logic              halt;
  logic              branch;
  logic [TGT_W-1:0]  target;
  logic              ex_valid;
  logic [2:0]        ex_op;
  logic [5:0]        ex_arg;
  logic              done;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    output go, instruction, zero_in, zero_we, lut_we, lut_addr, lut_data,
    input  start, halt, branch, target, ex_valid, ex_op, ex_arg, done, instr_count
  );

  modport slave (
    input  go, instruction, zero_in, zero_we, lut_we, lut_addr, lut_data,
    output start, halt, branch, target, ex_valid, ex_op, ex_arg, done, instr_count
  );
endinterface

// File: rtl/branch_lut.sv
// Branch-target table: synchronous write, combinational read, async clear.
module branch_lut
  import ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [LUT_AW-1:0] i_waddr,
  input  logic [TGT_W-1:0]  i_wdata,
  input  logic [LUT_AW-1:0] i_raddr,
  output logic [TGT_W-1:0]  o_rdata
);
  logic [TGT_W-1:0] r_mem [LUT_DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LUT_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-write contents during the write cycle.
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ctrl_decode.sv
// Decode/sequencing stage: drives fetch controls, resolves branches, forwards ops.
// state     | meaning
// ST_IDLE   | after reset, fetch held, waiting for go
// ST_START  | one cycle, fetch PC <= 0, clears count/done/zero flag
// ST_RUN    | decoding the instruction at the current PC
// ST_HALTED | HALT seen, fetch held, done high, waiting for go
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  ctrl_decode_if.slave io_bus
);
  state_t           r_state, w_next;
  logic             r_zero;
  logic             r_done;
  logic             r_ex_valid;
  logic [2:0]       r_ex_op;
  logic [5:0]       r_ex_arg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_flag;
  logic             w_run;
  logic             w_is_br, w_is_brz, w_is_halt, w_ordinary;
  logic [TGT_W-1:0] w_lut_rdata;
  logic             w_start, w_halt, w_branch;
  logic [TGT_W-1:0] w_target;

  branch_lut u_lut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (io_bus.lut_we),
    .i_waddr (io_bus.lut_addr),
    .i_wdata (io_bus.lut_data),
    .i_raddr (io_bus.instruction[LUT_AW-1:0]),
    .o_rdata (w_lut_rdata)
  );

  assign w_run      = (r_state == ST_RUN);
  assign w_is_br    = (io_bus.instruction[8:6] == OP_BR);
  assign w_is_brz   = (io_bus.instruction[8:6] == OP_BRZ);
  assign w_is_halt  = (io_bus.instruction == INSTR_HALT);
  assign w_ordinary = !(w_is_br || w_is_brz || w_is_halt);
  // Same-cycle zero update from execute bypasses the register.
  assign w_flag     = io_bus.zero_we ? io_bus.zero_in : r_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_halt   = 1'b0;
    w_branch = 1'b0;
    w_target = '0;
    case (r_state)
      ST_IDLE: begin
        w_halt = 1'b1;
        if (io_bus.go) w_next = ST_START;
      end
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_RUN;
      end
      ST_RUN: begin
        if (w_is_br || w_is_brz) w_target = w_lut_rdata;
        w_branch = w_is_br || (w_is_brz && w_flag);
        if (w_is_halt) begin
          w_halt = 1'b1;
          w_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_halt = 1'b1;
        if (io_bus.go) w_next = ST_START;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_arg   <= '0;
      r_cnt      <= '0;
    end else begin
      r_ex_valid <= w_run && w_ordinary;
      if (w_run && w_ordinary) begin
        r_ex_op  <= io_bus.instruction[8:6];
        r_ex_arg <= io_bus.instruction[5:0];
      end
      if (r_state == ST_START) begin
        r_zero <= 1'b0;
        r_done <= 1'b0;
        r_cnt  <= '0;
      end else begin
        if (io_bus.zero_we) r_zero <= io_bus.zero_in;
        if (w_run && w_is_halt) r_done <= 1'b1;
        if (w_run && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.start       = w_start;
  assign io_bus.halt        = w_halt;
  assign io_bus.branch      = w_branch;
  assign io_bus.target      = w_target;
  assign io_bus.ex_valid    = r_ex_valid;
  assign io_bus.ex_op       = r_ex_op;
  assign io_bus.ex_arg      = r_ex_arg;
  assign io_bus.done        = r_done;
  assign io_bus.instr_count = r_cnt;
endmodule
